decod_seq: RTL and testbench



---
 rtl/decod_seq_if.sv | 27 ++
 rtl/decod_seq.sv | 111 +++++++++++
 tb/tb_decod_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/decod_seq_if.sv
// decod_seq_if: request handshake and decoder drive bundle for decod_seq.
// The requester holds the master side; decod_seq holds the slave side.
interface decod_seq_if #(
  parameter int unsigned DWELL_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_line;
  logic [DWELL_W-1:0] req_dwell;
  logic               pi0;
  logic               pi1;
  logic               pi2;
  logic               pi3;
  logic               pi4;
  logic               busy;
  logic               done;

  modport master (
    output req_valid, req_line, req_dwell,
    input  req_ready, pi0, pi1, pi2, pi3, pi4, busy, done
  );

  modport slave (
    input  req_valid, req_line, req_dwell,
    output req_ready, pi0, pi1, pi2, pi3, pi4, busy, done
  );
endinterface

// File: rtl/decod_seq.sv
// decod_seq: FIFO-buffered line-select sequencer feeding the 16-line decod decoder,
// one line at a time for a programmed dwell, with a one-cycle break-before-make gap.
module decod_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  decod_seq_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t             state, state_nx;
  logic [3:0]         line_mem  [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [3:0]         code;
  logic               pi4_q, done_q;
  logic               ready, push, pop;
  logic [3:0]         head_line;
  logic [DWELL_W-1:0] head_dwell;

  assign ready      = (count != FULL);
  assign push       = bus.req_valid & ready;
  assign head_line  = line_mem[rd_ptr];
  assign head_dwell = dwell_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      line_mem[wr_ptr]  <= bus.req_line;
      dwell_mem[wr_ptr] <= bus.req_dwell;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Pop only looks at the registered count, so a request is never bypassed
  // straight to the decoder in the cycle it is accepted.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        cnt_nx = cnt - DWELL_W'(1);
        if (cnt == DWELL_W'(1)) state_nx = GAP;
      end
      GAP: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = DRIVE;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (pop) cnt_nx = (head_dwell == '0) ? DWELL_W'(1) : head_dwell;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      code   <= '1;
      pi4_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pi4_q  <= (state_nx == DRIVE);
      done_q <= (state_nx == GAP);
      if (pop) code <= ~head_line;
    end
  end

  // code[3] is pi0 (= ~n[3]) down to code[0] is pi3 (= ~n[0]).
  assign bus.pi0       = code[3];
  assign bus.pi1       = code[2];
  assign bus.pi2       = code[1];
  assign bus.pi3       = code[0];
  assign bus.pi4       = pi4_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE) || (count != '0);
  assign bus.req_ready = ready;
endmodule

// File: tb/tb_decod_seq.sv
// tb_decod_seq: table-driven vectors, hand-timed corner sequences and a
// queue scoreboard of {code, dwell} per accepted request for decod_seq.
module tb_decod_seq;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DWELL_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decod_seq_if #(.DWELL_W(DWELL_W)) bus ();
  decod_seq #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [3:0] code; int len; } exp_t;
  typedef struct { logic [3:0] line; logic [7:0] dwell; logic [3:0] code; int len; } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_acc = 0;
  int   acc_at_stall = -1;
  bit   bp_mode = 1'b0;

  logic       prev_pi4 = 1'b0;
  logic [3:0] run_code = 4'h0;
  int         run_len = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] code_of(logic [3:0] l);
    return {~l[3], ~l[2], ~l[1], ~l[0]};
  endfunction

  function automatic logic [3:0] cur_code();
    return {bus.pi0, bus.pi1, bus.pi2, bus.pi3};
  endfunction

  // Selection monitor: measures each pi4 run and compares against the scoreboard.
  always @(negedge clk) begin
    logic run_end;
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_pi4 = 1'b0;
      run_len  = 0;
    end else begin
      run_end = prev_pi4 && !bus.pi4;
      if (bus.done || run_end) chk("done_pulse", int'(bus.done), int'(run_end));
      if (bus.pi4 && !prev_pi4) begin
        run_code = cur_code();
        run_len  = 1;
      end else if (bus.pi4) begin
        run_len++;
        if (cur_code() != run_code) chk("code_stable", int'(cur_code()), int'(run_code));
      end
      if (run_end) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_sel", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sel_code", int'(run_code), int'(e.code));
          chk("sel_len", run_len, e.len);
        end
      end
      prev_pi4 = bus.pi4;
    end
  end

  // Returns 1ns after the accepting edge with req_valid dropped.
  task automatic send(input logic [3:0] l, input logic [7:0] d,
                      input logic [3:0] ec, input int el);
    bit   ok = 1'b0;
    logic r;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_line  = l;
    bus.req_dwell = d;
    for (int i = 0; i < 4000 && !ok; i++) begin
      r = bus.req_ready;
      if (!r && bp_mode && acc_at_stall < 0) acc_at_stall = n_acc;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        n_acc++;
        sb.push_back('{ec, el});
      end else begin
        @(negedge clk);
      end
    end
    #1 bus.req_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!bus.busy && sb.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    vec_t tbl [8];
    bit   bad;
    logic [3:0] l;
    logic [7:0] d;
    int   pat_pi4  [6];
    int   pat_done [6];

    bus.req_valid = 1'b0;
    bus.req_line  = '0;
    bus.req_dwell = '0;

    tbl[0] = '{4'd0,  8'd3,   4'b1111, 3};
    tbl[1] = '{4'd15, 8'd1,   4'b0000, 1};
    tbl[2] = '{4'd5,  8'd3,   4'b1010, 3};
    tbl[3] = '{4'd12, 8'd0,   4'b0011, 1};
    tbl[4] = '{4'd9,  8'd2,   4'b0110, 2};
    tbl[5] = '{4'd6,  8'd0,   4'b1001, 1};
    tbl[6] = '{4'd3,  8'd255, 4'b1100, 255};
    tbl[7] = '{4'd10, 8'd4,   4'b0101, 4};
    pat_pi4  = '{1, 1, 0, 1, 1, 0};
    pat_done = '{0, 0, 1, 0, 0, 1};

    // Reset state
    #12;
    chk("rst_pi4",  int'(bus.pi4), 0);
    chk("rst_code", int'(cur_code()), 4'hF);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    #11 rst = 1'b0;
    #1 chk("rst_ready", int'(bus.req_ready), 1);

    // Table vectors, each from an idle block
    for (int i = 0; i < 8; i++) begin
      wait_idle(50);
      send(tbl[i].line, tbl[i].dwell, tbl[i].code, tbl[i].len);
      wait_idle(600);
    end

    // Single request latency: line 5, dwell 3
    send(4'd5, 8'd3, 4'b1010, 3);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk("lat_pi4_hi", int'(bus.pi4), 1);
      chk("lat_code", int'(cur_code()), 4'b1010);
    end
    @(posedge clk); #1;
    chk("lat_gap_pi4", int'(bus.pi4), 0);
    chk("lat_gap_done", int'(bus.done), 1);
    chk("lat_gap_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    chk("lat_busy_fall", int'(bus.busy), 0);
    chk("lat_done_fall", int'(bus.done), 0);
    wait_idle(50);

    // Back-to-back same line: pi4 1,1,0,1,1,0
    send(4'd0, 8'd2, 4'b1111, 2);
    send(4'd0, 8'd2, 4'b1111, 2);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      chk("b2b_pi4", int'(bus.pi4), pat_pi4[c]);
      chk("b2b_done", int'(bus.done), pat_done[c]);
      chk("b2b_code", int'(cur_code()), 4'b1111);
    end
    wait_idle(50);

    // Backpressure: lines 1..8, dwell 10, valid held
    bp_mode = 1'b1;
    n_acc = 0;
    acc_at_stall = -1;
    for (int i = 1; i <= 8; i++) begin
      l = 4'(i);
      send(l, 8'd10, code_of(l), 10);
    end
    bp_mode = 1'b0;
    chk("bp_stall_after", acc_at_stall, 5);
    wait_idle(200);

    // Reset mid-DRIVE of line 12 with two entries queued
    send(4'd12, 8'd10, 4'b0011, 10);
    send(4'd3, 8'd5, 4'b1100, 5);
    send(4'd7, 8'd5, 4'b1000, 5);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_pi4", int'(bus.pi4), 1);
    chk("mid_code", int'(cur_code()), 4'b0011);
    #1 rst = 1'b1;
    #1;
    chk("arst_pi4", int'(bus.pi4), 0);
    chk("arst_code", int'(cur_code()), 4'hF);
    chk("arst_busy", int'(bus.busy), 0);
    #14 rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.pi4 || bus.done || bus.busy) bad = 1'b1;
    end
    chk("post_rst_quiet", int'(bad), 0);
    chk("post_rst_ready", int'(bus.req_ready), 1);
    chk("post_rst_sb_empty", sb.size(), 0);

    // Random traffic
    for (int i = 0; i < 2200; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      l = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 6));
      send(l, d, code_of(l), (d == 8'd0) ? 1 : int'(d));
    end
    wait_idle(200);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
